// File: rtl/fu_pkg.sv
// fu_pkg: types and helpers shared by the FU buffer bank.
//   fifo_mode_e : per-channel operating mode
//   ch_ctl_t    : mode/enable bits common to every channel config word
//   ch_cfg_w()  : width of one channel config word for a given pointer width
package fu_pkg;

  typedef enum logic {
    FIFO_MODE  = 1'b0,
    DELAY_MODE = 1'b1
  } fifo_mode_e;

  // The delay field width depends on DEPTH. A package cannot be
  // parameterised, so each channel appends delay[AW-1:0] to this header
  // to form its full ch_cfg_t.
  typedef struct packed {
    fifo_mode_e mode;
    logic       rd_en;
    logic       wr_en;
  } ch_ctl_t;

  localparam int CH_CTL_W = $bits(ch_ctl_t);

  function automatic int ch_cfg_w(input int aw);
    return aw + CH_CTL_W;
  endfunction

endpackage

// File: rtl/fu_fifo_ch.sv
// fu_fifo_ch: one buffer channel. It runs as a FIFO or as a programmable delay line.
//   clk, rst_n        clock, async active-low reset
//   cfg_i             active config {mode, rd_en, wr_en, delay}
//   flush_i           mode-changing commit: drop contents, pointers, count and flags
//   rewarm_i          delay-changing commit in delay mode: restart warm-up
//   clear_i           clear sticky ovf/udf; an error set in the same cycle wins
//   data_i            write data
//   data_o, valid_o   registered read data and one-cycle update strobe
//   count_o, full_o, empty_o, ovf_o, udf_o   occupancy and status
module fu_fifo_ch
  import fu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CFG_W     = ch_cfg_w(AW),
  localparam int EW        = 2 * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic             flush_i,
  input  logic             rewarm_i,
  input  logic             clear_i,
  input  logic [EW-1:0]    data_i,
  output logic [EW-1:0]    data_o,
  output logic             valid_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             udf_o
);

  typedef struct packed {
    ch_ctl_t         ctl;
    logic [AW-1:0]   delay;
  } ch_cfg_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  ch_cfg_t cfg;
  assign cfg = cfg_i;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, rd_idx;
  logic [AW:0]   count_q, count_d, d_len;
  logic [EW-1:0] data_q, data_d, rd_data;
  logic          valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          is_fifo, empty, full, rd_ok, wr_ok;

  // In delay mode, the sample written D advances ago sits at wp-D. This
  // includes D=DEPTH: that slot is the one being overwritten at this edge.
  // The read sees the old contents there, so every D in 1..DEPTH is exact
  // and no bypass is needed.
  assign rd_idx  = is_fifo ? rp_q : (wp_q - cfg.delay - AW'(1));
  assign rd_data = mem_q[rd_idx];

  always_comb begin
    is_fifo = (cfg.ctl.mode == FIFO_MODE);
    d_len   = {1'b0, cfg.delay} + ONE_C;
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    rd_ok   = is_fifo && cfg.ctl.rd_en && !empty;
    wr_ok   = is_fifo ? (cfg.ctl.wr_en && (!full || rd_ok)) : cfg.ctl.wr_en;

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q & ~clear_i;
    udf_d   = udf_q & ~clear_i;

    if (wr_ok) wp_d = wp_q + AW'(1);

    if (is_fifo) begin
      if (rd_ok) begin
        rp_d    = rp_q + AW'(1);
        data_d  = rd_data;
        valid_d = 1'b1;
      end
      if (wr_ok && !rd_ok)      count_d = count_q + ONE_C;
      else if (rd_ok && !wr_ok) count_d = count_q - ONE_C;
      if (cfg.ctl.wr_en && full && !rd_ok) ovf_d = 1'b1;
      if (cfg.ctl.rd_en && empty)          udf_d = 1'b1;
    end else if (cfg.ctl.wr_en) begin
      if (count_q < d_len) count_d = count_q + ONE_C;
      // data_o only moves once the line is warm. During warm-up the ring
      // still holds stale samples from before the flush.
      if (count_q == d_len) begin
        data_d  = rd_data;
        valid_d = 1'b1;
      end
    end

    if (rewarm_i) count_d = '0;

    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = is_fifo && full;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: rtl/fu_fifo_bank.sv
// fu_fifo_bank: NUM_CH independent FIFO / delay-line channels. Each channel is
// controlled by a double-buffered config word.
//   clk, rst_n   clock, async active-low reset
//   config_i     shadow config, channel i at [i*CH_CFG_W +: CH_CFG_W],
//                packed {mode, rd_en, wr_en, delay}
//   cfg_commit   copies config_i into the active config at this edge
//   clear_i      per-channel sticky flag clear
//   data_i/o     per-channel data, channel i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   valid_o, count_o, full_o, empty_o, ovf_o, udf_o   per-channel status
module fu_fifo_bank
  import fu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CH_CFG_W  = ch_cfg_w(AW),
  localparam int EW        = 2 * DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*CH_CFG_W-1:0] config_i,
  input  logic                       cfg_commit,
  input  logic [NUM_CH-1:0]          clear_i,
  input  logic [NUM_CH*EW-1:0]       data_i,
  output logic [NUM_CH*EW-1:0]       data_o,
  output logic [NUM_CH-1:0]          valid_o,
  output logic [NUM_CH*(AW+1)-1:0]   count_o,
  output logic [NUM_CH-1:0]          full_o,
  output logic [NUM_CH-1:0]          empty_o,
  output logic [NUM_CH-1:0]          ovf_o,
  output logic [NUM_CH-1:0]          udf_o
);

  localparam int MODE_B = CH_CFG_W - 1;

  logic [NUM_CH*CH_CFG_W-1:0] cfg_q, cfg_d;

  always_comb begin
    cfg_d = cfg_commit ? config_i : cfg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_q <= '0;
    else        cfg_q <= cfg_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic flush, rewarm;

    // Flush/rewarm are decided from the old (active) and new (shadow)
    // words at the commit edge. The channel still runs this cycle under
    // the old config.
    assign flush  = cfg_commit &&
                    (cfg_q[i*CH_CFG_W + MODE_B] != config_i[i*CH_CFG_W + MODE_B]);
    assign rewarm = cfg_commit &&
                    (cfg_q[i*CH_CFG_W + MODE_B] == DELAY_MODE) &&
                    (config_i[i*CH_CFG_W + MODE_B] == DELAY_MODE) &&
                    (cfg_q[i*CH_CFG_W +: AW] != config_i[i*CH_CFG_W +: AW]);

    fu_fifo_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_i    (cfg_q[i*CH_CFG_W +: CH_CFG_W]),
      .flush_i  (flush),
      .rewarm_i (rewarm),
      .clear_i  (clear_i[i]),
      .data_i   (data_i[i*EW +: EW]),
      .data_o   (data_o[i*EW +: EW]),
      .valid_o  (valid_o[i]),
      .count_o  (count_o[i*(AW+1) +: AW+1]),
      .full_o   (full_o[i]),
      .empty_o  (empty_o[i]),
      .ovf_o    (ovf_o[i]),
      .udf_o    (udf_o[i])
    );
  end

endmodule

// File: tb/tb_fu_fifo_bank.sv
module tb_fu_fifo_bank;
  import fu_pkg::*;

  localparam int DW    = 16;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = AW + 3;
  localparam int EW    = 2 * DW;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*CW-1:0]    config_i;
  logic                 cfg_commit;
  logic [NCH-1:0]       clear_i;
  logic [NCH*EW-1:0]    data_i;
  logic [NCH*EW-1:0]    data_o;
  logic [NCH-1:0]       valid_o;
  logic [NCH*(AW+1)-1:0] count_o;
  logic [NCH-1:0]       full_o, empty_o, ovf_o, udf_o;

  fu_fifo_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .config_i   (config_i),
    .cfg_commit (cfg_commit),
    .clear_i    (clear_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .ovf_o      (ovf_o),
    .udf_o      (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid0 = 0;
  int nv;
  logic [31:0] sb0 [$];
  logic [NCH*CW-1:0] cfg_sh;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input logic mode, input logic rd, input logic wr,
                         input logic [AW-1:0] dly);
    cfg_sh[ch*CW +: CW] = {mode, rd, wr, dly};
    config_i = cfg_sh;
  endtask

  // One cycle: inputs already driven, optional commit, advance to 2 units after the edge.
  task automatic cyc(input logic commit);
    cfg_commit = commit;
    @(posedge clk);
    #2;
    cfg_commit = 1'b0;
  endtask

  function automatic logic [4:0] cnt0();
    return count_o[4:0];
  endfunction

  // Scoreboard monitor: every valid on ch0 must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid_o[0]) begin
        n_valid0++;
        if (sb0.size() == 0) check("ch0_unexpected_valid", valid_o[0], 0);
        else                 check("ch0_data", data_o[31:0], sb0.pop_front());
      end
      if (rst_n && valid_o[1]) check("ch1_idle_valid", valid_o[1], 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; config_i = '0; cfg_sh = '0; cfg_commit = 1'b0; clear_i = '0; data_i = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 2'b11);
    check("rst_full", full_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_flags", {ovf_o, udf_o}, 0);
    check("rst_data", data_o, 0);
    #19 rst_n = 1'b1;
    @(posedge clk); #2;

    // 1: fill 16, overflow, drain in order
    set_cfg(0, FIFO_MODE, 1'b0, 1'b1, 0); cyc(1);
    for (int i = 1; i <= 16; i++) begin
      data_i[31:0] = 32'(i); sb0.push_back(32'(i)); cyc(0);
    end
    check("t1_count_full", cnt0(), 16);
    check("t1_full", full_o[0], 1);
    check("t1_no_ovf_yet", ovf_o[0], 0);
    data_i[31:0] = 32'h11; cyc(0);
    check("t1_ovf", ovf_o[0], 1);
    check("t1_count_stays", cnt0(), 16);
    check("t1_ch1_indep", {count_o[9:5], ovf_o[1], empty_o[1]}, {5'd0, 1'b0, 1'b1});
    set_cfg(0, FIFO_MODE, 1'b1, 1'b0, 0); cyc(1);
    nv = n_valid0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) set_cfg(0, FIFO_MODE, 1'b0, 1'b0, 0);
      cyc(i == 16);
    end
    cyc(0);
    check("t1_nvalid", n_valid0 - nv, 16);
    check("t1_sb_drained", sb0.size(), 0);
    check("t1_empty", {empty_o[0], cnt0()}, {1'b1, 5'd0});
    check("t1_ovf_sticky", ovf_o[0], 1);
    check("t1_no_udf", udf_o[0], 0);

    // 2: simultaneous read/write when full, then empty with rd+wr
    clear_i[0] = 1'b1; cyc(0); clear_i = '0;
    check("t2_clear", ovf_o[0], 0);
    set_cfg(0, FIFO_MODE, 1'b0, 1'b1, 0); cyc(1);
    for (int i = 1; i <= 16; i++) begin
      data_i[31:0] = 32'h100 + 32'(i); sb0.push_back(32'h100 + 32'(i));
      if (i == 16) set_cfg(0, FIFO_MODE, 1'b1, 1'b1, 0);
      cyc(i == 16);
    end
    data_i[31:0] = 32'hAAAA5555; sb0.push_back(32'hAAAA5555);
    set_cfg(0, FIFO_MODE, 1'b1, 1'b0, 0); cyc(1);
    check("t2_rw_full_count", cnt0(), 16);
    check("t2_rw_full_no_ovf", ovf_o[0], 0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) set_cfg(0, FIFO_MODE, 1'b1, 1'b1, 0);
      cyc(i == 16);
    end
    check("t2_last_is_aaaa", data_o[31:0], 32'hAAAA5555);
    check("t2_drained", cnt0(), 0);
    data_i[31:0] = 32'h0BAD0001; sb0.push_back(32'h0BAD0001);
    set_cfg(0, FIFO_MODE, 1'b1, 1'b0, 0); cyc(1);
    check("t2_udf", udf_o[0], 1);
    check("t2_count_one", cnt0(), 1);
    check("t2_no_bypass", valid_o[0], 0);
    set_cfg(0, FIFO_MODE, 1'b0, 1'b0, 0); cyc(1);
    cyc(0);
    check("t2_final_count", cnt0(), 0);
    check("t2_sb", sb0.size(), 0);

    // 5: same-mode commit keeps contents, commit-cycle read uses old config, mode change flushes
    set_cfg(0, FIFO_MODE, 1'b0, 1'b1, 0); cyc(1);
    for (int i = 1; i <= 5; i++) begin
      data_i[31:0] = 32'h200 + 32'(i); sb0.push_back(32'h200 + 32'(i));
      if (i == 5) set_cfg(0, FIFO_MODE, 1'b1, 1'b0, 0);
      cyc(i == 5);
    end
    check("t5_count5", cnt0(), 5);
    set_cfg(0, FIFO_MODE, 1'b0, 1'b0, 0); cyc(1);
    check("t5_commit_read_count", cnt0(), 4);
    check("t5_commit_read_valid", valid_o[0], 1);
    check("t5_commit_read_data", data_o[31:0], 32'h201);
    check("t5_udf_before_flush", udf_o[0], 1);
    set_cfg(0, DELAY_MODE, 1'b0, 1'b0, 3); cyc(1);
    sb0.delete();
    check("t5_flush_count", cnt0(), 0);
    check("t5_flush_flags", {ovf_o[0], udf_o[0], valid_o[0]}, 0);
    check("t5_flush_data_hold", data_o[31:0], 32'h201);

    // 3: delay D=4
    set_cfg(0, DELAY_MODE, 1'b0, 1'b1, 3); cyc(1);
    nv = n_valid0;
    for (int i = 1; i <= 4; i++) begin
      data_i[31:0] = 32'(i); sb0.push_back(32'(i)); cyc(0);
    end
    check("t3_d4_warm_count", cnt0(), 4);
    check("t3_d4_warm_valid", valid_o[0], 0);
    data_i[31:0] = 32'd5; sb0.push_back(32'd5); cyc(0);
    check("t3_d4_first_valid", valid_o[0], 1);
    check("t3_d4_first_data", data_o[31:0], 1);
    for (int i = 6; i <= 12; i++) begin
      data_i[31:0] = 32'(i); sb0.push_back(32'(i));
      if (i == 12) set_cfg(0, DELAY_MODE, 1'b0, 1'b0, 3);
      cyc(i == 12);
    end
    cyc(0);
    check("t3_d4_nvalid", n_valid0 - nv, 8);
    check("t3_d4_count_sat", cnt0(), 4);
    check("t3_d4_status", {full_o[0], ovf_o[0], udf_o[0]}, 0);

    // D=1 (rewarm via delay change)
    set_cfg(0, DELAY_MODE, 1'b0, 1'b1, 0); cyc(1);
    sb0.delete();
    check("t3_d1_rewarm", cnt0(), 0);
    nv = n_valid0;
    for (int i = 1; i <= 6; i++) begin
      data_i[31:0] = 32'h300 + 32'(i); sb0.push_back(32'h300 + 32'(i));
      if (i == 6) set_cfg(0, DELAY_MODE, 1'b0, 1'b0, 0);
      cyc(i == 6);
    end
    cyc(0);
    check("t3_d1_nvalid", n_valid0 - nv, 5);
    check("t3_d1_count", cnt0(), 1);

    // D=16
    set_cfg(0, DELAY_MODE, 1'b0, 1'b1, 15); cyc(1);
    sb0.delete();
    nv = n_valid0;
    for (int i = 1; i <= 20; i++) begin
      data_i[31:0] = 32'h500 + 32'(i); sb0.push_back(32'h500 + 32'(i));
      if (i == 20) set_cfg(0, DELAY_MODE, 1'b0, 1'b0, 15);
      cyc(i == 20);
    end
    cyc(0);
    check("t3_d16_nvalid", n_valid0 - nv, 4);
    check("t3_d16_count", cnt0(), 16);
    check("t3_d16_not_full", full_o[0], 0);
    check("t3_d16_last", data_o[31:0], 32'h504);

    // 4: D=2 with gaps between advances
    set_cfg(0, DELAY_MODE, 1'b0, 1'b1, 1); cyc(1);
    sb0.delete();
    nv = n_valid0;
    for (int k = 1; k <= 6; k++) begin
      data_i[31:0] = 32'h400 + 32'(k); sb0.push_back(32'h400 + 32'(k));
      set_cfg(0, DELAY_MODE, 1'b0, 1'b0, 1); cyc(1);
      data_i[31:0] = 32'hDEAD0000 + 32'(k);
      if (k < 6) set_cfg(0, DELAY_MODE, 1'b0, 1'b1, 1);
      cyc(k < 6);
      check("t4_gap_valid", valid_o[0], 0);
      check("t4_gap_hold", data_o[31:0], (k >= 3) ? 32'h400 + 32'(k - 2) : 32'h504);
    end
    cyc(0);
    check("t4_nvalid", n_valid0 - nv, 4);
    check("t4_count", cnt0(), 2);

    // 6: clear vs overflow, then async reset mid-stream
    set_cfg(0, FIFO_MODE, 1'b0, 1'b1, 0); cyc(1);
    sb0.delete();
    check("t6_flush", cnt0(), 0);
    for (int i = 1; i <= 16; i++) begin
      data_i[31:0] = 32'h600 + 32'(i); sb0.push_back(32'h600 + 32'(i)); cyc(0);
    end
    data_i[31:0] = 32'h617; clear_i[0] = 1'b1;
    set_cfg(0, FIFO_MODE, 1'b0, 1'b0, 0); cyc(1);
    clear_i = '0;
    check("t6_set_beats_clear", ovf_o[0], 1);
    clear_i[0] = 1'b1; cyc(0); clear_i = '0;
    check("t6_clear_alone", ovf_o[0], 0);
    check("t6_pre_rst_full", full_o[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_arst_count", count_o, 0);
    check("t6_arst_empty_full", {empty_o, full_o}, {2'b11, 2'b00});
    check("t6_arst_data", data_o, 0);
    check("t6_arst_flags", {valid_o, ovf_o, udf_o}, 0);
    sb0.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #2;
    data_i[31:0] = 32'h700; cyc(0); cyc(0);
    check("t6_cfg_reset_no_write", cnt0(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_fifo_bank.md
Name: fu_fifo_bank

Overview:
Parametrised successor to the two fixed FIFOs in the FU cluster. It provides NUM_CH independent buffer channels. Each channel runs as either a FIFO or a programmable delay line, selected by a double-buffered configuration word. Each channel reports occupancy, valid and sticky error status, so the cluster scheduler can pace the CMAC/CORDIC pipelines without hard-wired latency.

Parameters:
DATA_WIDTH, 16, width of one component; each entry is 2*DATA_WIDTH (complex)
NUM_CH, 2, number of channels (1..8)
DEPTH, 16, entries per channel; power of two, >=2
AW, $clog2(DEPTH), derived pointer width
CH_CFG_W, AW+3, derived per-channel config width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
config_i  in  NUM_CH*CH_CFG_W  shadow config; channel i at [i*CH_CFG_W +: CH_CFG_W], packed {mode, rd_en, wr_en, delay[AW-1:0]}
cfg_commit  in  1  pulse; copies config_i into active config
clear_i  in  NUM_CH  per-channel sticky-flag clear
data_i  in  NUM_CH x 2*DATA_WIDTH  write data
data_o  out  NUM_CH x 2*DATA_WIDTH  registered read data
valid_o  out  NUM_CH  one-cycle pulse, data_o updated this cycle
count_o  out  NUM_CH x (AW+1)  occupancy 0..DEPTH
full_o  out  NUM_CH  count==DEPTH (FIFO mode)
empty_o  out  NUM_CH  count==0
ovf_o  out  NUM_CH  sticky overflow
udf_o  out  NUM_CH  sticky underflow

Behaviour:
- Reset (async): active config all-zero (FIFO mode, rd/wr disabled). data_o=0, valid_o=0, count_o=0, empty_o=1, full_o=0, ovf_o=0, udf_o=0. Pointers are 0. Memory contents are don't-care.
- Config: the active config register loads on the clock edge where cfg_commit=1. The new config governs from the next cycle. Operations in the commit cycle use the old config.
- Commit that changes a channel's mode: flush that channel. Pointers=0, count=0, ovf/udf=0. data_o holds its value, valid_o=0 next cycle. A commit with the same mode does not flush.
- FIFO mode (mode=0):
  - Write accepted when wr_en && (!full || rd accepted same cycle).
  - Read accepted when rd_en && !empty. An empty FIFO with a simultaneous write rejects the read; there is no bypass.
  - Write latency: data written at edge t is readable from cycle t+1. A read accepted in cycle t drives data_o and valid_o=1 after edge t.
  - wr_en && full && no read: write dropped, ovf set.
  - rd_en && empty: udf set, data_o holds, valid_o=0.
  - count updates every cycle: +1 write only, -1 read only, unchanged for both or neither.
  - Pointers wrap modulo DEPTH.
- Delay mode (mode=1):
  - D = delay+1, range 1..DEPTH. rd_en is ignored.
  - Each cycle with wr_en=1 is an advance: data_i is stored and data_o <= the sample written D advances earlier.
  - D=1 means data_o equals the previous advance's data_i. The implementation must bypass or offset the ring so D=1..DEPTH are all exact.
  - count saturates at D and counts advances since the flush.
  - valid_o=1 on an advance only when count==D before that advance (warm-up suppressed).
  - full_o=0 and udf never sets. ovf never sets.
  - Changing delay without a mode change: count resets to 0 (re-warm) and the pointer is kept.
- clear_i[i]: clears ovf/udf at the edge. If an error event occurs in the same cycle, the set wins.
- Channels are fully independent. There is no combinational path from inputs to outputs.

Decomposition:
- Package fu_pkg:
  - typedef enum logic {FIFO_MODE=0, DELAY_MODE=1} fifo_mode_e
  - parameterisable packed struct ch_cfg_t {mode, rd_en, wr_en, delay}
  - shared CH_CFG_W helper
- Sub-module fu_fifo_ch: one channel holding the ring, pointers, count, flags and output register. The top level holds the active-config register, slices config, and has a generate loop over NUM_CH.

Test Plan:
1. Reset, then commit FIFO with wr_en=1 for 16 cycles (data 0x00000001..0x00000010) -> count_o=16, full_o=1; 17th write -> ovf_o=1, count stays 16; then rd_en for 16 cycles -> data_o 0x1..0x10 in order, valid_o each cycle, empty_o=1.
2. FIFO at count=16, rd_en=wr_en=1 with data 0xAAAA5555 -> count stays 16, no ovf; the value appears after 16 further reads. Empty with rd_en=wr_en=1 -> udf_o=1, count=1.
3. Commit delay mode delay=3 (D=4), wr_en=1 with ramp 1,2,3... -> valid_o first high on advance 5 with data_o=1; then data_o tracks input-4. Repeat with delay=0 (D=1) and delay=15 (D=16).
4. Delay mode, wr_en toggling 1,0,1,0 -> data_o and valid_o change only on advances, delay measured in advances.
5. FIFO holding 5 entries, commit to delay mode -> count_o=0, ovf/udf=0 next cycle. Commit same-mode config -> no flush. cfg_commit coincident with rd_en -> the read executes under the old config.
6. Assert rst_n low mid-stream (async, between edges) -> all outputs return to reset values immediately; clear_i coincident with overflow -> ovf_o remains 1.
